riscv_cpu_top: RTL and testbench
================================

Name: riscv_cpu_top

Overview:
Single-cycle RV32I processor core. It is the top of the CPU and talks to an external instruction ROM and data RAM over separate Harvard-style ports. Both memories are read combinationally and written on the rising clock edge. Testbenches wrap it with simple array memories and run compiled C/assembly kernels (e.g. FFT/DFT) from address 0.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
i_mem_addr  output  32  byte address of current instruction (= PC)
i_mem_rdata  input  32  instruction word at i_mem_addr, valid same cycle
d_mem_addr  output  32  byte address of load/store (rs1 + imm, unmasked)
d_mem_wdata  output  32  store data, lane-replicated
d_mem_wen  output  4  byte write enables; 4'b0000 when not storing
d_mem_rdata  input  32  word containing d_mem_addr, valid same cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert): PC=RESET_PC; all 31 registers x1..x31 = 0. While rst=1: i_mem_addr=RESET_PC, d_mem_wen=0. First fetch happens in the cycle after rst deasserts; reset mid-program aborts the current instruction with no register or memory write.
- Single-cycle datapath, CPI=1:
  - Fetch, decode, execute, memory access and writeback all occur in one cycle.
  - PC and rd update at the rising edge.
  - Store is committed by the memory at that same edge.
- x0 reads 0; writes to x0 are discarded. Register file: 2 combinational read ports, 1 write port.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit0 cleared), BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Next PC: PC+4 normally; PC+imm on taken branch or JAL; (rs1+imm)&~1 on JALR. Link value is PC+4. Arithmetic wraps mod 2^32. Shift amount is the low 5 bits.
- Loads:
  - Byte lane selected by d_mem_addr[1:0]; halfword lane by d_mem_addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend. Misaligned LW/LH are not trapped: lane selection uses the address bits as-is.
- Stores:
  - SW: wen=1111, wdata=rs2.
  - SH: wen=0011 or 1100 per addr[1], wdata={2{rs2[15:0]}}.
  - SB: wen=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - d_mem_wen is combinational and nonzero only during the store instruction's cycle.
- d_mem_addr is driven for every instruction (ALU sum) and is only meaningful for loads/stores.
- FENCE, ECALL, EBREAK, CSR ops and any undefined opcode execute as NOP: PC+4, no writes.
- No traps, interrupts or stall inputs; the memories are zero-wait-state.

Optional Feature:
- Macro RV32M_MUL_EN. Defined: decode OP funct7=0000001 funct3 000..011 as MUL/MULH/MULHSU/MULHU with full 32x32 products, written to rd in the same cycle. funct3 100..111 (div/rem) remain NOP.
- Undefined: all funct7=0000001 OP encodings are NOPs (no rd write).

Test Plan:
- Reset held 5 cycles then released -> i_mem_addr=0x0 during reset, 0x4 after first edge, d_mem_wen=0 throughout reset.
- ADDI x1,x0,0x400; ADDI x2,x0,-5; SW x2,0(x1) -> d_mem_addr=0x400, d_mem_wen=1111, d_mem_wdata=0xFFFFFFFB in the SW cycle.
- SB x2,3(x1) then LB x3,3(x1) / LBU x4,3(x1) against RAM holding 0xFB000000 at 0x400 -> wen=1000, wdata=0xFBFBFBFB; x3=0xFFFFFFFB, x4=0x000000FB.
- BLT x2,x1,+8 (-5<1024) taken, BLTU not taken; JAL x5,+16 at PC 0x20 -> x5=0x24, PC=0x30; JALR to odd target clears bit0.
- ADDI x0,x0,7 then SW x0 -> stored 0; SRAI 0x80000000 by 4 -> 0xF8000000; undefined opcode 0x00000000 -> PC+4, no writes.
- With RV32M_MUL_EN: MUL 0x7FFFFFFF*3 -> 0x7FFFFFFD, MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. Without the macro: same encodings leave rd unchanged.

Source files
------------

// File: rtl/riscv_cpu_top.sv
// riscv_cpu_top: single-cycle RV32I core with separate instruction and data ports.
// Define RV32M_MUL_EN to add MUL/MULH/MULHSU/MULHU; otherwise those encodings are NOPs.
module riscv_cpu_top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] d_mem_addr,
  output logic [31:0] d_mem_wdata,
  output logic [3:0]  d_mem_wen,
  input  logic [31:0] d_mem_rdata
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc;
  logic [31:0] regs [1:31];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  assign instr  = i_mem_rdata;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic signed [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'sd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'sd0 : regs[rs2];

  // Shared adder for load/store/JALR addressing; also exposed on d_mem_addr.
  logic [31:0] addr_sum;
  assign addr_sum = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  assign ld_byte = d_mem_rdata[{addr_sum[1:0], 3'b000} +: 8];
  assign ld_half = addr_sum[1] ? d_mem_rdata[31:16] : d_mem_rdata[15:0];

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic signed [31:0] a,
                                      input logic signed [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << sh;
      3'b010:  alu = {31'b0, a < b};
      3'b011:  alu = {31'b0, $unsigned(a) < $unsigned(b)};
      3'b100:  alu = a ^ b;
      3'b110:  alu = a | b;
      3'b111:  alu = a & b;
      default: begin
        if (alt) alu = a >>> sh;
        else     alu = $unsigned(a) >> sh;
      end
    endcase
  endfunction

`ifdef RV32M_MUL_EN
  // One 33x33 signed multiplier covers all four variants via per-operand sign extension.
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_p;
  assign mul_a = {(funct3[1:0] != 2'b11) & rs1_val[31], rs1_val};
  assign mul_b = {~funct3[1] & rs2_val[31], rs2_val};
  assign mul_p = 64'(mul_a * mul_b);
`endif

  logic [31:0] next_pc, wb_val, st_wdata;
  logic [3:0]  st_wen;
  logic        wb_en, take;

  always_comb begin
    next_pc  = pc + 32'd4;
    wb_en    = 1'b0;
    wb_val   = '0;
    st_wen   = 4'b0000;
    st_wdata = rs2_val;
    take     = 1'b0;
    case (opcode)
      OP_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      OP_AUIPC: begin
        wb_en  = 1'b1;
        wb_val = pc + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_val  = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_val  = pc + 32'd4;
          next_pc = {addr_sum[31:1], 1'b0};
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  take = (rs1_val == rs2_val);
          3'b001:  take = (rs1_val != rs2_val);
          3'b100:  take = (rs1_val < rs2_val);
          3'b101:  take = (rs1_val >= rs2_val);
          3'b110:  take = ($unsigned(rs1_val) < $unsigned(rs2_val));
          3'b111:  take = ($unsigned(rs1_val) >= $unsigned(rs2_val));
          default: take = 1'b0;
        endcase
        if (take) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        wb_en = 1'b1;
        case (funct3)
          3'b000:  wb_val = {{24{ld_byte[7]}}, ld_byte};
          3'b001:  wb_val = {{16{ld_half[15]}}, ld_half};
          3'b010:  wb_val = d_mem_rdata;
          3'b100:  wb_val = {24'b0, ld_byte};
          3'b101:  wb_val = {16'b0, ld_half};
          default: wb_en  = 1'b0;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'b000: begin
            st_wen   = 4'b0001 << addr_sum[1:0];
            st_wdata = {4{rs2_val[7:0]}};
          end
          3'b001: begin
            st_wen   = addr_sum[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{rs2_val[15:0]}};
          end
          3'b010:  st_wen = 4'b1111;
          default: st_wen = 4'b0000;
        endcase
      end
      OP_IMM: begin
        if (funct3 == 3'b001) wb_en = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) wb_en = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else wb_en = 1'b1;
        wb_val = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_val, imm_i);
      end
      OP_REG: begin
        if (funct7 == 7'b0000000) begin
          wb_en  = 1'b1;
          wb_val = alu(funct3, 1'b0, rs1_val, rs2_val);
        end else if (funct7 == 7'b0100000) begin
          wb_en  = (funct3 == 3'b000) || (funct3 == 3'b101);
          wb_val = alu(funct3, 1'b1, rs1_val, rs2_val);
        end
`ifdef RV32M_MUL_EN
        else if (funct7 == 7'b0000001 && !funct3[2]) begin
          wb_en  = 1'b1;
          wb_val = (funct3[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
    end
  end

  assign i_mem_addr  = pc;
  assign d_mem_addr  = addr_sum;
  assign d_mem_wdata = st_wdata;
  assign d_mem_wen   = rst ? 4'b0000 : st_wen;
endmodule

// File: tb/tb_riscv_cpu_top.sv
// tb_riscv_cpu_top: runs a directed RV32I program against an instruction-level model
// and a hand-computed table of the stores the program must emit.
module tb_riscv_cpu_top;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_mem_addr, i_mem_rdata, d_mem_addr, d_mem_wdata, d_mem_rdata;
  logic [3:0]  d_mem_wen;

  riscv_cpu_top #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .i_mem_addr(i_mem_addr), .i_mem_rdata(i_mem_rdata),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_wen(d_mem_wen), .d_mem_rdata(d_mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] ram  [512];
  assign i_mem_rdata = imem[i_mem_addr[9:2]];
  assign d_mem_rdata = ram[d_mem_addr[10:2]];
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (d_mem_wen[i]) ram[d_mem_addr[10:2]][8*i +: 8] <= d_mem_wdata[8*i +: 8];

  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int r1, int f3, int rd, logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(r1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int r2, int r1, int f3);
    logic [31:0] v = imm;
    return {v[11:5], 5'(r2), 5'(r1), 3'(f3), v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int r2, int r1, int f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(r2), 5'(r1), 3'(f3), v[4:1], v[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
    logic [31:0] v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int r2, int r1, int f3, int rd);
    return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  // Instruction-set model: architectural state plus its own copy of data memory.
  logic [31:0] m_pc;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [512];
  bit run_model = 0;

  typedef struct { logic [31:0] addr; logic [3:0] wen; logic [31:0] wdata; } st_t;
  st_t log_q[$];

  function automatic logic [31:0] m_alu(input logic [2:0] f3, input bit alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (run_model) begin
      logic [31:0] ins, a, b, nxt, ea, wv, wd, iI, iS, iB, iJ, w, lane;
      logic [63:0] p;
      logic [3:0]  we;
      logic [2:0]  f3;
      logic [6:0]  f7;
      bit wr, ld;
      ins = imem[m_pc[9:2]];
      f3 = ins[14:12];
      f7 = ins[31:25];
      a = m_reg[ins[19:15]];
      b = m_reg[ins[24:20]];
      iI = 32'($signed(ins) >>> 20);
      iS = (iI & ~32'h1F) | {27'b0, ins[11:7]};
      iB = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      iJ = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      nxt = m_pc + 4; wr = 0; wv = 0; ld = 0; we = 0; wd = 0; ea = 0;
      case (ins[6:0])
        7'h37: begin wr = 1; wv = ins & 32'hFFFFF000; end
        7'h17: begin wr = 1; wv = m_pc + (ins & 32'hFFFFF000); end
        7'h6F: begin wr = 1; wv = m_pc + 4; nxt = m_pc + iJ; end
        7'h67: if (f3 == 0) begin wr = 1; wv = m_pc + 4; nxt = (a + iI) & ~32'd1; end
        7'h63: begin
          bit t;
          case (f3)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = $signed(a) < $signed(b);
            3'd5: t = !($signed(a) < $signed(b));
            3'd6: t = a < b;
            3'd7: t = !(a < b);
            default: t = 0;
          endcase
          if (t) nxt = m_pc + iB;
        end
        7'h03: begin
          ea = a + iI; ld = 1; wr = 1;
          w = m_mem[ea[10:2]];
          lane = (w >> (8 * ea[1:0])) & 32'hFF;
          if (f3 == 0) wv = (lane ^ 32'h80) - 32'h80;
          else if (f3 == 4) wv = lane;
          else if (f3 == 1) wv = ((ea[1] ? w >> 16 : w & 32'hFFFF) ^ 32'h8000) - 32'h8000;
          else if (f3 == 5) wv = ea[1] ? w >> 16 : w & 32'hFFFF;
          else if (f3 == 2) wv = w;
          else wr = 0;
        end
        7'h23: begin
          ea = a + iS;
          if (f3 == 0) begin we = 4'(1 << ea[1:0]); wd = (b & 32'hFF) * 32'h01010101; end
          if (f3 == 1) begin we = ea[1] ? 4'hC : 4'h3; wd = (b & 32'hFFFF) * 32'h00010001; end
          if (f3 == 2) begin we = 4'hF; wd = b; end
        end
        7'h13: begin
          wr = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
          wv = m_alu(f3, (f3 == 5) && f7 == 7'h20, a, iI);
        end
        7'h33: begin
          if (f7 == 0) begin wr = 1; wv = m_alu(f3, 0, a, b); end
          else if (f7 == 7'h20) begin wr = (f3 == 0 || f3 == 5); wv = m_alu(f3, 1, a, b); end
`ifdef RV32M_MUL_EN
          else if (f7 == 1 && f3 < 4) begin
            wr = 1;
            case (f3)
              3'd0: p = {32'b0, a} * {32'b0, b};
              3'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
              3'd2: p = {{32{a[31]}}, a} * {32'b0, b};
              default: p = {32'b0, a} * {32'b0, b};
            endcase
            wv = (f3 == 0) ? p[31:0] : p[63:32];
          end
`endif
        end
        default: ;
      endcase
      check("i_mem_addr", i_mem_addr, m_pc);
      check("d_mem_wen", {28'b0, d_mem_wen}, {28'b0, we});
      if (ld || we != 0) check("d_mem_addr", d_mem_addr, ea);
      if (we != 0) check("d_mem_wdata", d_mem_wdata, wd);
      if (d_mem_wen != 0) log_q.push_back('{d_mem_addr, d_mem_wen, d_mem_wdata});
      for (int i = 0; i < 4; i++) if (we[i]) m_mem[ea[10:2]][8*i +: 8] = wd[8*i +: 8];
      if (wr && ins[11:7] != 0) m_reg[ins[11:7]] = wv;
      m_pc = nxt;
    end
  end

  logic [31:0] ex_addr  [16];
  logic [3:0]  ex_wen   [16];
  logic [31:0] ex_wdata [16];

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 512; i++) begin ram[i] = 32'h0; m_mem[i] = 32'h0; end
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_pc = 32'h0;
    imem[0]  = enc_s(32'h500, 0, 0, 2);
    imem[1]  = enc_i(32'h400, 0, 0, 1, 7'h13);
    imem[2]  = enc_i(-5, 0, 0, 2, 7'h13);
    imem[3]  = enc_s(0, 2, 1, 2);
    imem[4]  = enc_s(0, 0, 1, 2);
    imem[5]  = enc_s(3, 2, 1, 0);
    imem[6]  = enc_i(3, 1, 0, 3, 7'h03);
    imem[7]  = enc_i(3, 1, 4, 4, 7'h03);
    imem[8]  = enc_j(16, 5);
    imem[9]  = enc_i(1, 0, 0, 6, 7'h13);
    imem[10] = enc_i(1, 0, 0, 6, 7'h13);
    imem[11] = enc_i(1, 0, 0, 6, 7'h13);
    imem[12] = enc_s(32'h10, 3, 1, 2);
    imem[13] = enc_s(32'h14, 4, 1, 2);
    imem[14] = enc_s(32'h18, 5, 1, 2);
    imem[15] = enc_b(8, 1, 2, 4);
    imem[16] = enc_i(1, 0, 0, 6, 7'h13);
    imem[17] = enc_b(8, 1, 2, 6);
    imem[18] = enc_i(2, 6, 0, 6, 7'h13);
    imem[19] = enc_s(32'h1C, 6, 1, 2);
    imem[20] = enc_i(7, 0, 0, 0, 7'h13);
    imem[21] = enc_s(32'h20, 0, 1, 2);
    imem[22] = enc_u(32'h80000, 7, 7'h37);
    imem[23] = enc_i(32'h404, 7, 5, 7, 7'h13);
    imem[24] = enc_s(32'h24, 7, 1, 2);
    imem[25] = 32'h0000_0000;
    imem[26] = enc_u(0, 8, 7'h17);
    imem[27] = enc_i(32'h11, 8, 0, 9, 7'h67);
    imem[28] = enc_i(99, 0, 0, 6, 7'h13);
    imem[29] = enc_i(99, 0, 0, 6, 7'h13);
    imem[30] = enc_s(32'h28, 9, 1, 2);
    imem[31] = enc_i(-1, 0, 0, 10, 7'h13);
    imem[32] = enc_u(32'h80000, 11, 7'h37);
    imem[33] = enc_i(-1, 11, 0, 11, 7'h13);
    imem[34] = enc_i(3, 0, 0, 12, 7'h13);
    imem[35] = enc_i(32'h55, 0, 0, 13, 7'h13);
    imem[36] = enc_i(32'h66, 0, 0, 14, 7'h13);
    imem[37] = enc_r(1, 12, 11, 0, 13);
    imem[38] = enc_r(1, 10, 10, 3, 14);
    imem[39] = enc_s(32'h2C, 13, 1, 2);
    imem[40] = enc_s(32'h30, 14, 1, 2);
    imem[41] = enc_r(32'h20, 11, 12, 0, 15);
    imem[42] = enc_s(32'h34, 15, 1, 2);
    imem[43] = enc_i(2, 1, 1, 16, 7'h03);
    imem[44] = enc_s(32'h38, 16, 1, 2);
    imem[45] = enc_s(32'h3A, 2, 1, 1);
    imem[46] = enc_j(0, 0);

    ex_addr  = '{32'h500, 32'h400, 32'h400, 32'h403, 32'h410, 32'h414, 32'h418, 32'h41C,
                 32'h420, 32'h424, 32'h428, 32'h42C, 32'h430, 32'h434, 32'h438, 32'h43A};
    ex_wen   = '{4'hF, 4'hF, 4'hF, 4'h8, 4'hF, 4'hF, 4'hF, 4'hF,
                 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hC};
`ifdef RV32M_MUL_EN
    ex_wdata = '{32'h0, 32'hFFFFFFFB, 32'h0, 32'hFBFBFBFB, 32'hFFFFFFFB, 32'h000000FB,
                 32'h24, 32'h2, 32'h0, 32'hF8000000, 32'h70, 32'h7FFFFFFD, 32'hFFFFFFFE,
                 32'h80000004, 32'hFFFFFB00, 32'hFFFBFFFB};
`else
    ex_wdata = '{32'h0, 32'hFFFFFFFB, 32'h0, 32'hFBFBFBFB, 32'hFFFFFFFB, 32'h000000FB,
                 32'h24, 32'h2, 32'h0, 32'hF8000000, 32'h70, 32'h55, 32'h66,
                 32'h80000004, 32'hFFFFFB00, 32'hFFFBFFFB};
`endif

    #3 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("reset_pc", i_mem_addr, 32'h0);
      check("reset_wen", {28'b0, d_mem_wen}, 32'h0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    run_model = 1;
    @(negedge clk);
    @(negedge clk);
    check("first_fetch_pc", i_mem_addr, 32'h4);
    repeat (70) @(negedge clk);

    // Abort mid-program: asynchronous reset must take effect without a clock edge.
    @(posedge clk);
    #1 run_model = 0;
    #2 rst = 1'b1;
    #1;
    check("midrun_reset_pc", i_mem_addr, 32'h0);
    check("midrun_reset_wen", {28'b0, d_mem_wen}, 32'h0);

    check("model_x3", m_reg[3], 32'hFFFFFFFB);
    check("model_x4", m_reg[4], 32'h000000FB);
    check("model_x5", m_reg[5], 32'h24);
    check("model_x7", m_reg[7], 32'hF8000000);
    check("model_x9", m_reg[9], 32'h70);
    check("model_pc_loop", m_pc, 32'hB8);
    check("store_count", log_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      check($sformatf("store%0d_addr", i), log_q[i].addr, ex_addr[i]);
      check($sformatf("store%0d_wen", i), {28'b0, log_q[i].wen}, {28'b0, ex_wen[i]});
      check($sformatf("store%0d_wdata", i), log_q[i].wdata, ex_wdata[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
